// File: rtl/byte_stream_packer.sv
// Packs an 8-bit AXI-Stream byte stream into DATA_BYTES-wide words with a valid-byte count.
// Optional macro STREAM_PACK_TRUNC_EN: one word per packet; over-long packets are truncated and flagged.
module byte_stream_packer #(
  parameter int DATA_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  output logic [DATA_BYTES*8-1:0] o_data,
  output logic                    o_tvalid,
  input  logic                    o_tready,
  output logic [7:0]              o_len,
  output logic                    o_last,
  output logic                    o_overflow
);
  localparam int CNT_W = $clog2(DATA_BYTES + 1);
  localparam int W     = DATA_BYTES * 8;

`ifdef STREAM_PACK_TRUNC_EN
  typedef enum logic [1:0] {FILL, EMIT, DROP} state_t;
`else
  typedef enum logic {FILL, EMIT} state_t;
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_data;
  logic [7:0]       r_len;
  logic             r_s_tready;
  logic             r_tvalid;
  logic             r_last;
`ifdef STREAM_PACK_TRUNC_EN
  logic             r_overflow;
`endif

  logic [W-1:0]     w_word;
  logic [8:0]       w_cnt_p1;
  logic             w_full;
  logic             w_byte_xfer;
  logic             w_word_xfer;

  assign w_cnt_p1    = 9'(r_cnt) + 9'd1;
  assign w_full      = (w_cnt_p1 == 9'(DATA_BYTES));
  assign w_byte_xfer = s_tvalid && r_s_tready;
  assign w_word_xfer = r_tvalid && o_tready;

  // Incoming byte overlays lane r_cnt; lanes above it are still zero in the accumulator.
  generate
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
      assign w_word[gi*8 +: 8] = (r_cnt == CNT_W'(gi)) ? s_tdata : r_acc[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FILL;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_data     <= '0;
      r_len      <= '0;
      r_s_tready <= 1'b0;
      r_tvalid   <= 1'b0;
      r_last     <= 1'b0;
`ifdef STREAM_PACK_TRUNC_EN
      r_overflow <= 1'b0;
`endif
    end else begin
      case (r_state)
        FILL: begin
          r_s_tready <= 1'b1;
          if (w_byte_xfer) begin
            if (w_full || s_tlast) begin
              r_data     <= w_word;
              r_len      <= w_cnt_p1[7:0];
              r_acc      <= '0;
              r_cnt      <= '0;
              r_tvalid   <= 1'b1;
              r_s_tready <= 1'b0;
              r_state    <= EMIT;
`ifdef STREAM_PACK_TRUNC_EN
              // Every word closes its packet; a full word without tlast means the rest is dropped.
              r_last     <= 1'b1;
              r_overflow <= !s_tlast;
`else
              r_last     <= s_tlast;
`endif
            end else begin
              r_acc <= w_word;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        EMIT: begin
          if (w_word_xfer) begin
            r_tvalid   <= 1'b0;
            r_s_tready <= 1'b1;
`ifdef STREAM_PACK_TRUNC_EN
            r_state    <= r_overflow ? DROP : FILL;
`else
            r_state    <= FILL;
`endif
          end
        end
`ifdef STREAM_PACK_TRUNC_EN
        DROP: begin
          r_s_tready <= 1'b1;
          if (w_byte_xfer && s_tlast) begin
            r_state <= FILL;
          end
        end
`endif
        default: r_state <= FILL;
      endcase
    end
  end

  assign s_tready = r_s_tready;
  assign o_data   = r_data;
  assign o_tvalid = r_tvalid;
  assign o_len    = r_len;
  assign o_last   = r_last;
`ifdef STREAM_PACK_TRUNC_EN
  assign o_overflow = r_overflow;
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: doc/byte_stream_packer.md
Name: byte_stream_packer

Overview:
- Upstream stage of the wide-word register buffer in the Ethernet receive path.
- Accepts an 8-bit AXI-Stream byte stream from the MAC/parser side.
- Packs bytes into one DATA_BYTES-wide word plus a byte count (mem_len).
- Presents word and count with a valid/ready handshake to the downstream register stage.

Parameters:
DATA_BYTES, 16, bytes per output word; legal range 1..255.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
s_tdata  input  8  input byte
s_tvalid  input  1  input byte valid
s_tready  output  1  packer can accept a byte
s_tlast  input  1  marks the last byte of a packet
o_data  output  DATA_BYTES*8  packed word; first byte of the word in [7:0]
o_tvalid  output  1  word and length are valid
o_tready  input  1  downstream accepts the word
o_len  output  8  number of valid bytes in o_data, 1..DATA_BYTES
o_last  output  1  word holds the last byte of a packet
o_overflow  output  1  packet exceeded DATA_BYTES and was truncated (feature only)

Behaviour:
- Reset (async assert, sync release):
  - o_data=0, o_len=0, o_tvalid=0, o_last=0, o_overflow=0.
  - s_tready=0 during reset; s_tready=1 on the first clock after release.
  - Byte counter=0; state=FILL.
- Byte transfer occurs on a cycle with s_tvalid&&s_tready.
- Word transfer occurs on a cycle with o_tvalid&&o_tready.
- FILL state:
  - s_tready=1, o_tvalid=0.
  - Each accepted byte is written to lane [cnt*8+:8] of an internal accumulator, then cnt increments.
  - Leave FILL when cnt+1==DATA_BYTES or s_tlast: latch the word into the o_data register, set o_len=cnt+1, set o_last=s_tlast, reset cnt to 0, go to EMIT.
- EMIT state:
  - o_tvalid=1, s_tready=0.
  - o_data, o_len and o_last are held stable until transfer.
  - On transfer: o_tvalid=0 next cycle; go to FILL, or to DROP per the optional feature.
- Latency: o_tvalid rises on the clock edge that accepts the completing byte, so the word is visible the cycle after that byte.
- Unused lanes: bytes at index o_len..DATA_BYTES-1 are zero in o_data.
- No bubble on the input side beyond the EMIT phase: a byte is accepted in FILL the cycle after the word transfer.
- tlast on byte DATA_BYTES exactly: one word, o_len=DATA_BYTES, o_last=1.
- DATA_BYTES=1: every byte forms its own word with o_len=1.
- o_tready held high: throughput is DATA_BYTES bytes per DATA_BYTES+1 cycles.
- Mid-operation reset: the partial word and any pending output are discarded; no word is emitted after reset release until new bytes arrive.
- o_len width: 8 bits; the counter is sized ceil(log2(DATA_BYTES+1)) bits, zero-extended to 8.

Optional Feature:
Macro STREAM_PACK_TRUNC_EN.
- Defined:
  - A packet produces exactly one word.
  - If DATA_BYTES bytes fill without s_tlast, the word is emitted with o_last=1 and o_overflow=1. After that word transfers, the block enters DROP.
  - DROP state: s_tready=1, bytes are discarded, o_tvalid=0. On the tlast byte go to FILL.
  - o_overflow clears on the next latched word.
- Not defined:
  - Long packets are split into successive words. o_last=1 only on the word containing the tlast byte.
  - o_overflow is tied to 0; DROP state is not built.

Test Plan:
- Reset, then 4 bytes 0x11,0x22,0x33,0x44 with tlast on 0x44, DATA_BYTES=16, o_tready=1 → one word, o_data[31:0]=0x44332211, upper bytes 0, o_len=4, o_last=1, o_tvalid high exactly 1 cycle.
- Packet of exactly 16 bytes 0x00..0x0F with tlast on the 16th → o_len=16, o_last=1, o_data[127:120]=0x0F, o_overflow=0.
- 20-byte packet, macro undefined → word1 o_len=16 o_last=0; word2 o_len=4 o_last=1 holding bytes 16..19.
- 20-byte packet, macro defined → single word o_len=16 o_last=1 o_overflow=1; bytes 16..19 consumed with s_tready=1 and no o_tvalid; next 2-byte packet yields o_len=2, o_overflow=0.
- Backpressure: o_tready=0 for 5 cycles after o_tvalid → s_tready=0 and o_data/o_len stable for all 5 cycles; transfer on the cycle o_tready=1; input accepted on the following cycle.
- Assert rst_n low after 7 of 10 bytes → all outputs 0 immediately; a fresh 3-byte packet after release gives o_len=3 with only the new bytes.
